// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: default geometry, FSM state
// encodings and port-select encodings.
package mem_responder_pkg;

   localparam int MEM_DEPTH_WORDS = 4096;
   localparam int MEM_WAIT_CYCLES = 2;

   localparam logic [1:0] MEMST_IDLE = 2'd0;
   localparam logic [1:0] MEMST_WAIT = 2'd1;
   localparam logic [1:0] MEMST_RESP = 2'd2;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with a registered read port.
// Contents are deliberately not reset.
module mem_array #(
   parameter int WORD_LEN    = 32,
   parameter int DEPTH_WORDS = 4096
) (
   input  logic                           clk,
   input  logic                           we_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
   input  logic [WORD_LEN-1:0]            wdata_i,
   output logic [WORD_LEN-1:0]            rdata_o
);

   logic [WORD_LEN-1:0] mem_q [DEPTH_WORDS];
   logic [WORD_LEN-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
      rdata_q <= mem_q[idx_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Cycle-accurate memory responder serving the instruction and data ports from
// one shared array. Optional access checking is enabled by ERR_CHECK_EN.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int WORD_LEN    = 32,
   parameter int DEPTH_WORDS = MEM_DEPTH_WORDS,
   parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ireq,
   input  logic [WORD_LEN-1:0] iaddr,
   output logic                iack,
   output logic [WORD_LEN-1:0] inst,
   output logic                ierr,
   input  logic                dreq,
   input  logic                dwen,
   input  logic [WORD_LEN-1:0] daddr,
   input  logic [WORD_LEN-1:0] dwdata,
   output logic                dack,
   output logic [WORD_LEN-1:0] drdata,
   output logic                derr
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   logic [1:0]          state_q, state_d;
   logic [3:0]          waitCnt_q, waitCnt_d;
   logic                port_q, wen_q;
   logic [IDX_W-1:0]    idx_q;
   logic [WORD_LEN-1:0] wdata_q, inst_q, drdata_q;

   logic                grant, grantWen, grantErr, respErr, enterResp, useLive;
   logic [WORD_LEN-1:0] grantAddr, respData, rdata;
   logic [IDX_W-1:0]    accIdx;
   logic                accWen, accErr, memWe, resp;
   logic [WORD_LEN-1:0] accWdata;

   // D has fixed priority over I whenever both are pending in IDLE.
   assign grant     = (state_q == MEMST_IDLE) && (dreq || ireq);
   assign grantAddr = dreq ? daddr : iaddr;
   assign grantWen  = dreq && dwen;

`ifdef ERR_CHECK_EN
   logic err_q;

   assign grantErr = (grantAddr[1:0] != 2'b00) || (grantAddr[WORD_LEN-1:IDX_W+2] != '0);
   assign respErr  = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (grant) begin
         err_q <= grantErr;
      end
   end
`else
   logic unusedAddrBits;

   assign unusedAddrBits = ^{grantAddr[WORD_LEN-1:IDX_W+2], grantAddr[1:0]};
   assign grantErr = 1'b0;
   assign respErr  = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      case (state_q)
         MEMST_IDLE: begin
            if (grant) begin
               if (WAIT_CYCLES > 0) begin
                  state_d   = MEMST_WAIT;
                  waitCnt_d = WAIT_LOAD;
               end else begin
                  state_d = MEMST_RESP;
               end
            end
         end
         MEMST_WAIT: begin
            if (waitCnt_q == 4'd0) begin
               state_d = MEMST_RESP;
            end else begin
               waitCnt_d = waitCnt_q - 4'd1;
            end
         end
         MEMST_RESP: state_d = MEMST_IDLE;
         default:    state_d = MEMST_IDLE;
      endcase
   end

   // With zero wait states RESP is entered straight from IDLE, so the array
   // must see the live request rather than the not-yet-latched copy.
   assign useLive   = (state_q == MEMST_IDLE);
   assign enterResp = (state_d == MEMST_RESP) && (state_q != MEMST_RESP);
   assign accIdx    = useLive ? grantAddr[IDX_W+1:2] : idx_q;
   assign accWen    = useLive ? grantWen : wen_q;
   assign accWdata  = useLive ? dwdata : wdata_q;
   assign accErr    = useLive ? grantErr : respErr;
   assign memWe     = enterResp && accWen && !accErr;

   mem_array #(
      .WORD_LEN   (WORD_LEN),
      .DEPTH_WORDS(DEPTH_WORDS)
   ) uArray (
      .clk    (clk),
      .we_i   (memWe),
      .idx_i  (accIdx),
      .wdata_i(accWdata),
      .rdata_o(rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= MEMST_IDLE;
         waitCnt_q <= 4'd0;
         port_q    <= PORT_I;
         wen_q     <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         inst_q    <= '0;
         drdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         if (grant) begin
            port_q  <= dreq ? PORT_D : PORT_I;
            wen_q   <= grantWen;
            idx_q   <= grantAddr[IDX_W+1:2];
            wdata_q <= dwdata;
         end
         if (iack) begin
            inst_q <= respData;
         end
         if (dack && !wen_q) begin
            drdata_q <= respData;
         end
      end
   end

   assign resp     = (state_q == MEMST_RESP);
   assign respData = respErr ? '0 : rdata;
   assign iack     = resp && (port_q == PORT_I);
   assign dack     = resp && (port_q == PORT_D);
   assign ierr     = iack && respErr;
   assign derr     = dack && respErr;
   assign inst     = iack ? respData : inst_q;
   assign drdata   = (dack && !wen_q) ? respData : drdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed handshake, priority and reset scenarios
// followed by random traffic against a word-array reference model.
module tb_mem_responder;

   localparam int W     = 2;
   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ireq = 1'b0, dreq = 1'b0, dwen = 1'b0;
   logic [31:0] iaddr = '0, daddr = '0, dwdata = '0;
   logic        iack, ierr, dack, derr;
   logic [31:0] inst, drdata;

   logic        zIreq = 1'b0, zDreq = 1'b0, zDwen = 1'b0;
   logic [31:0] zIaddr = '0, zDaddr = '0, zDwdata = '0;
   logic        zIack, zIerr, zDack, zDerr;
   logic [31:0] zInst, zDrdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int prevAck0 = 0;
   logic [31:0] model [int];
   logic [31:0] model0 [int];
   logic [31:0] expInst = '0;
   logic [31:0] expDr = '0;

   mem_responder #(.WORD_LEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ireq(ireq), .iaddr(iaddr), .iack(iack), .inst(inst), .ierr(ierr),
      .dreq(dreq), .dwen(dwen), .daddr(daddr), .dwdata(dwdata),
      .dack(dack), .drdata(drdata), .derr(derr)
   );

   mem_responder #(.WORD_LEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .ireq(zIreq), .iaddr(zIaddr), .iack(zIack), .inst(zInst), .ierr(zIerr),
      .dreq(zDreq), .dwen(zDwen), .daddr(zDaddr), .dwdata(zDwdata),
      .dack(zDack), .drdata(zDrdata), .derr(zDerr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit errOf(input logic [31:0] a);
`ifdef ERR_CHECK_EN
      return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`else
      return 1'b0;
`endif
   endfunction

   function automatic int idxOf(input logic [31:0] a);
      return int'((a >> 2) % 32'(DEPTH));
   endfunction

   // Called just after a negedge in an IDLE cycle, which is cycle 0 of the request.
   task automatic applyStimulus(input bit isD, input bit wen, input logic [31:0] addr,
                                input logic [31:0] wdata);
      int ackC;
      bit e;
      logic [31:0] expData;
      e = errOf(addr);
      ackC = -1;
      if (isD) begin
         dreq = 1'b1; dwen = wen; daddr = addr; dwdata = wdata;
      end else begin
         ireq = 1'b1; iaddr = addr;
      end
      for (int c = 1; c < 40; c++) begin
         @(negedge clk);
         checkOutput("otherAckLow", {31'b0, isD ? iack : dack}, 32'd0);
         if (isD ? dack : iack) begin
            ackC = c;
            break;
         end
      end
      if (ackC < 0) begin
         checkOutput("ackTimeout", 32'd0, 32'd1);
         dreq = 1'b0; ireq = 1'b0;
         @(negedge clk);
         return;
      end
      checkOutput("latency", ackC, W + 1);
      if (isD && wen) begin
         if (!e) model[idxOf(addr)] = wdata;
         checkOutput("derrWrite", {31'b0, derr}, {31'b0, e});
         checkOutput("drdataKeptOnWrite", drdata, expDr);
      end else begin
         expData = e ? 32'd0 : (model.exists(idxOf(addr)) ? model[idxOf(addr)] : 32'hx);
         if (isD) begin
            expDr = expData;
            checkOutput("derrRead", {31'b0, derr}, {31'b0, e});
            if (!$isunknown(expData)) checkOutput("drdata", drdata, expData);
         end else begin
            expInst = expData;
            checkOutput("ierr", {31'b0, ierr}, {31'b0, e});
            if (!$isunknown(expData)) checkOutput("inst", inst, expData);
         end
      end
      dreq = 1'b0; ireq = 1'b0;
      @(negedge clk);
      checkOutput("ackPulse", {31'b0, isD ? dack : iack}, 32'd0);
      if (isD) begin
         if (!$isunknown(expDr)) checkOutput("drdataHeld", drdata, expDr);
      end else begin
         if (!$isunknown(expInst)) checkOutput("instHeld", inst, expInst);
      end
   endtask

   task automatic runZeroWait(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                              input bit checkSpacing);
      int ackC;
      ackC = -1;
      zDreq = 1'b1; zDwen = wen; zDaddr = addr; zDwdata = wdata;
      for (int c = 1; c < 20; c++) begin
         @(negedge clk);
         if (zDack) begin
            ackC = c;
            break;
         end
      end
      checkOutput("zeroWaitLatency", ackC, 1);
      if (ackC > 0) begin
         if (wen) model0[idxOf(addr)] = wdata;
         else checkOutput("zeroWaitData", zDrdata, model0[idxOf(addr)]);
         if (checkSpacing) checkOutput("zeroWaitSpacing", cyc - prevAck0, 2);
         prevAck0 = cyc;
      end
      zDreq = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int dAckC, iAckC;
      logic [31:0] a;
      #1;
      checkOutput("rstIack", {31'b0, iack}, 32'd0);
      checkOutput("rstDack", {31'b0, dack}, 32'd0);
      checkOutput("rstInst", inst, 32'd0);
      checkOutput("rstDrdata", drdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h0, 32'h00000013);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

      // Simultaneous requests: D first, I served in the following IDLE cycle.
      dAckC = -1; iAckC = -1;
      dreq = 1'b1; dwen = 1'b0; daddr = 32'h10; ireq = 1'b1; iaddr = 32'h0;
      for (int c = 1; c < 40 && iAckC < 0; c++) begin
         @(negedge clk);
         checkOutput("bothAckHigh", {31'b0, iack & dack}, 32'd0);
         if (dack && dAckC < 0) begin
            dAckC = c;
            checkOutput("prioDrdata", drdata, model[idxOf(32'h10)]);
            dreq = 1'b0;
         end
         if (iack) begin
            iAckC = c;
            checkOutput("prioInst", inst, model[idxOf(32'h0)]);
            ireq = 1'b0;
         end
      end
      dreq = 1'b0; ireq = 1'b0;
      expDr = model[idxOf(32'h10)];
      expInst = model[idxOf(32'h0)];
      checkOutput("prioDackCycle", dAckC, W + 1);
      checkOutput("prioIackCycle", iAckC, 2 * W + 3);
      @(negedge clk);

      applyStimulus(1'b1, 1'b1, 32'h2, 32'hCAFEF00D);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h4000, 32'h0);

      // Reset during WAIT must abort the write and produce no ack.
      applyStimulus(1'b1, 1'b1, 32'h20, 32'h11111111);
      dreq = 1'b1; dwen = 1'b1; daddr = 32'h20; dwdata = 32'h22222222;
      @(negedge clk);
      rst_n = 1'b0;
      dreq = 1'b0;
      #1;
      checkOutput("midRstDack", {31'b0, dack}, 32'd0);
      checkOutput("midRstDerr", {31'b0, derr}, 32'd0);
      checkOutput("midRstIerr", {31'b0, ierr}, 32'd0);
      checkOutput("midRstInst", inst, 32'd0);
      checkOutput("midRstDrdata", drdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("midRstNoAck", {31'b0, dack | iack}, 32'd0);
      rst_n = 1'b1;
      expDr = 32'd0;
      expInst = 32'd0;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);

      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 32'(i * 4), $urandom);
      for (int n = 0; n < 40; n++) begin
         a = 32'($urandom_range(0, 15) * 4);
         case ($urandom_range(0, 7))
            0: a = a | 32'($urandom_range(1, 3));
            1: a = a + 32'(DEPTH * 4 * $urandom_range(1, 3));
            default: ;
         endcase
         if ($urandom_range(0, 2) == 0) applyStimulus(1'b0, 1'b0, a, 32'h0);
         else applyStimulus(1'b1, 1'($urandom_range(0, 1)), a, $urandom);
      end

      runZeroWait(1'b1, 32'h0, 32'hA0A0A0A0, 1'b0);
      runZeroWait(1'b1, 32'h4, 32'hB1B1B1B1, 1'b1);
      runZeroWait(1'b1, 32'h8, 32'hC2C2C2C2, 1'b1);
      runZeroWait(1'b0, 32'h0, 32'h0, 1'b1);
      runZeroWait(1'b0, 32'h4, 32'h0, 1'b1);
      runZeroWait(1'b0, 32'h8, 32'h0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's instruction port and data port.
- A single shared word array serves both request/ack channels, with a fixed-priority arbiter and a configurable wait-state counter.
- Sits between the core and the backing RAM in the SoC top. It replaces the ad-hoc combinational memory model with a cycle-accurate responder.

Parameters:
- WORD_LEN, 32, data/address width in bits.
- DEPTH_WORDS, 4096, number of 32-bit words (16 KiB). Must be a power of two.
- WAIT_CYCLES, 2, extra cycles between accept and response (0..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- ireq  in  1  instruction read request, held until iack
- iaddr  in  WORD_LEN  instruction byte address
- iack  out  1  one-cycle response pulse, instruction port
- inst  out  WORD_LEN  fetched instruction, valid when iack=1 and held until next iack
- ierr  out  1  instruction access error, qualified by iack
- dreq  in  1  data request, held until dack
- dwen  in  1  1=write, 0=read, held with dreq
- daddr  in  WORD_LEN  data byte address
- dwdata  in  WORD_LEN  write data
- dack  out  1  one-cycle response pulse, data port
- drdata  out  WORD_LEN  read data, valid when dack=1 and held until next read ack
- derr  out  1  data access error, qualified by dack

Behaviour:
- Clock and reset:
  - Reset is rst_n, asynchronous, active-low; the clock is clk.
  - On reset: state=IDLE, wait counter=0, iack=dack=ierr=derr=0, inst=drdata=0.
  - Array contents are not reset.
- States:
  - IDLE: sample requests at the clock edge.
    - dreq=1 -> grant D.
    - else ireq=1 -> grant I.
    - Grant latches port select, word index, dwen and dwdata.
    - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At 0 -> RESP.
  - RESP: ack for the granted port is high for exactly this cycle; next state is always IDLE.
- Array access:
  - Happens on the edge entering RESP.
  - Read: registered into inst or drdata.
  - Write: array[idx] <= dwdata (full word only). drdata is unchanged on write acks.
- Latency: ack is asserted WAIT_CYCLES+1 cycles after the cycle in which the request was accepted. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- Handshake rules:
  - Requester holds req, addr, wen and wdata stable until it sees ack.
  - Requester deasserts req at the edge ending the ack cycle; a req still high in IDLE is a new request.
  - Inputs changing after grant have no effect on the transaction in flight.
- Simultaneous ireq and dreq in IDLE: D wins. I is granted in the next IDLE cycle (the requester keeps ireq held). Fixed priority, no fairness counter.
- Address decode: index = addr[log2(DEPTH_WORDS)+1:2]. Bits [1:0] are ignored, and upper bits alias (wrap-around) unless ERR_CHECK_EN is defined.
- Reset mid-transaction: the transaction is aborted. A write whose RESP edge has not occurred is not committed, and no ack is issued.
- The I port never writes.

Optional Feature:
- Macro: ERR_CHECK_EN.
- Defined:
  - Granted access with addr[1:0]!=0, or addr >= DEPTH_WORDS*4, raises the port's err together with its ack (same cycle).
  - On error, the write is suppressed and read data is forced to 0.
- Undefined:
  - ierr and derr are tied 0.
  - Misaligned addresses are truncated and out-of-range addresses alias.
  - No check logic is synthesized.

Decomposition:
- consts.vh gains:
  - MEM_DEPTH_WORDS
  - MEM_WAIT_CYCLES
  - State encodings MEMST_IDLE, MEMST_WAIT, MEMST_RESP (2-bit)
  - Port-select encodings PORT_I, PORT_D
- Sub-module mem_array: single-port synchronous RAM with one clk, we, index, wdata and a registered rdata. It is instanced once; all arbitration and the FSM stay in mem_responder.

Test Plan:
1. WAIT_CYCLES=2, dreq/dwen=1, daddr=0x10, dwdata=0xDEADBEEF at cycle 0 -> dack in cycle 3. Read of 0x10 -> dack 3 cycles after accept, drdata=0xDEADBEEF.
2. D write 0x00000013 to 0x0, then ireq iaddr=0x0 -> iack pulse for one cycle, inst=0x00000013, held after iack falls.
3. ireq and dreq both rise in cycle 0 (WAIT_CYCLES=2) -> dack in cycle 3, iack in cycle 7, never both high in the same cycle.
4. Prior value 0x11111111 at 0x20; write 0x22222222 and assert rst_n=0 during WAIT -> no ack. The read after reset returns 0x11111111, and all outputs are 0 during reset.
5. WAIT_CYCLES=0, back-to-back D reads of 0x0, 0x4, 0x8 -> dack every 2 cycles, one cycle after each accept, with correct data.
6. ERR_CHECK_EN defined:
   - Write daddr=0x2 -> dack with derr=1, word at 0x0 unchanged.
   - Read daddr=0x4000 -> derr=1, drdata=0.
   - Without the macro, daddr=0x4000 aliases to word 0.
